clock_scan_ctrl: RTL and testbench
==================================

Name: clock_scan_ctrl

Overview:
Parametrised successor to the fixed 4-digit clock top. Keeps HH:MM:SS time directly in BCD, so no binary-to-BCD stage is needed. Adds an interactive set-time FSM, 12/24-hour display mode with leading-zero blanking, and blinking of the field being set. Drives an N-digit multiplexed 7-segment display (4 = HHMM, 6 = HHMMSS) through the existing hex-to-segment decoder, and takes its time-base and scan strobes from the clock divider.

Parameters:
- NUM_DIGITS, 4: displayed digits; legal values 4 or 6, anything else is an elaboration error.
- SEL_ACTIVE_LOW, 1: 1 = seg_sel is active-low one-hot; 0 = active-high.

Ports:
- clk  in  1  system clock (50 MHz).
- RESETn  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- enable  in  1  1 = timekeeping and buttons active; 0 = time and FSM frozen, scanning continues.
- tick_sec  in  1  one-clk strobe, once per second.
- scan_tick  in  1  one-clk strobe that advances the digit scan.
- btn_mode  in  1  one-clk debounced pulse; cycles the FSM state.
- btn_inc  in  1  one-clk debounced pulse; increments the field being set.
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display.
- seg_digit  out  4  BCD value of the currently selected digit, to the decoder.
- seg_blank  out  1  1 = selected digit dark; decoder output is overridden.
- seg_dp  out  1  decimal point of the selected digit (active-high).
- seg_sel  out  NUM_DIGITS  one-hot digit select.
- pm_led  out  1  PM indicator.
- sec_led  out  1  seconds blink LED.
- day_carry  out  1  one-clk pulse on 23:59:59 -> 00:00:00.
- time_bcd  out  24  {hour_t, hour_o, min_t, min_o, sec_t, sec_o}, always in 24-hour form.

Behaviour:
- Reset (RESETn=0 at a clk edge):
  - time 00:00:00, state RUN, scan index 0, blink_phase 0.
  - seg_sel all inactive; seg_digit 0; seg_blank 1; seg_dp 0.
  - pm_led 0; sec_led 0; day_carry 0.
  - Reset in the middle of a set operation discards the partial setting.
- FSM states RUN, SET_HOUR, SET_MIN.
  - btn_mode: RUN -> SET_HOUR -> SET_MIN -> RUN.
  - On entry to SET_HOUR, seconds are cleared to 00.
- Timekeeping (RUN only, enable=1):
  - Each tick_sec increments sec. sec 59 -> 00 carries to min; min 59 -> 00 carries to hour; hour 23 -> 00.
  - day_carry is asserted in the clk cycle after the tick that wraps 23:59:59.
  - Seconds are held in both SET states.
- Set mode (enable=1):
  - btn_inc in SET_HOUR: hour+1, 23 -> 00, no other field changes.
  - btn_inc in SET_MIN: min+1, 59 -> 00, no carry into hour.
  - btn_inc in RUN is ignored.
- Priority in a single cycle:
  - btn_mode beats btn_inc; the inc is dropped.
  - RUN with btn_mode and tick_sec together: the tick is dropped and sec is cleared.
- enable=0: all state, time and the FSM are held; all strobes and buttons are ignored.
- blink_phase: toggles on every tick_sec (enable=1, any state). In SET states, the digits of the field being set show seg_blank=1 while blink_phase=1.
- Display mapping (combinational from time_bcd):
  - 24-hour mode: hours shown as 00-23.
  - 12-hour mode: 00 -> 12; 01-12 unchanged; 13-23 -> 01-11. pm_led = (hour >= 12). Hour-tens digit is blanked when its displayed value is 0.
  - pm_led = 0 in 24-hour mode.
- Scan:
  - On scan_tick the index advances 0..NUM_DIGITS-1 and wraps. Digit 0 is rightmost: min_o for NUM_DIGITS=4, sec_o for NUM_DIGITS=6.
  - seg_sel, seg_digit, seg_blank and seg_dp are registered and update in the clk cycle after scan_tick (latency 1).
  - seg_sel never has more than one digit active.
- Decimal points: seg_dp=1 on the hour-ones digit when sec_o is odd (colon flash); 0 on all other digits.
- sec_led: equals sec_o[0] in RUN; 1 in SET states.

Decomposition:
- Shared package clock_pkg:
  - state encodings RUN / SET_HOUR / SET_MIN;
  - BCD limits: ONES_MAX 9, SEC_MIN_TENS_MAX 5, HOUR_WRAP 8'h23;
  - NUM_DIGITS legality check.
- Sub-module bcd_pair_counter, reused three times for sec, min and hour:
  - parameters WRAP_TENS and WRAP_ONES;
  - inputs inc, clr; outputs tens, ones and a registered wrap carry.

Test Plan:
- Release reset, 3 scan_ticks, NUM_DIGITS=4 -> seg_sel walks digits 0,1,2 one cycle after each tick; seg_digit = 0,0,0; time_bcd = 24'h000000.
- Preload 23:59:58 via the set path, then 2 tick_sec -> time_bcd 24'h235959, then 24'h000000; day_carry is high for exactly 1 clk.
- RUN, btn_mode -> SET_HOUR with sec=00. 24 btn_inc -> hour wraps back to 00. btn_mode, then 61 btn_inc -> min=01 with hour unchanged. btn_mode -> RUN.
- mode_12h=1, hour=00 / 12 / 13 -> displayed 12 / 12 / 01; pm_led = 0 / 1 / 1; hour-tens blank=1 for 01.
- btn_mode and btn_inc in the same cycle in SET_HOUR -> state becomes SET_MIN and hour is unchanged. tick_sec with btn_mode in RUN -> SET_HOUR with sec=00.
- enable=0 with 5 tick_sec and 2 btn_inc -> time_bcd and state unchanged while seg_sel keeps scanning. RESETn low during SET_MIN -> RUN at 00:00:00.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the BCD clock: FSM state encoding, BCD digit limits and
// the legality rule for the number of scanned digits.
package clock_pkg;

    typedef enum logic [1:0] {
        StRun,
        StSetHour,
        StSetMin
    } state_e;

    localparam logic [3:0] ONES_MAX         = 4'd9;
    localparam logic [3:0] SEC_MIN_TENS_MAX = 4'd5;
    localparam logic [7:0] HOUR_WRAP        = 8'h23;

    function automatic bit num_digits_ok(input int unsigned n);
        return (n == 4) || (n == 6);
    endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter that wraps to 00 after {WRAP_TENS, WRAP_ONES}.
// carry is a registered one-cycle pulse for the increment that wrapped.
module bcd_pair_counter
    import clock_pkg::*;
#(
    parameter logic [3:0] WRAP_TENS = SEC_MIN_TENS_MAX,
    parameter logic [3:0] WRAP_ONES = ONES_MAX
) (
    input  logic       clk,
    input  logic       RESETn,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    logic [3:0] tens_q;
    logic [3:0] ones_q;
    logic       carry_q;
    logic       at_wrap;

    assign at_wrap = (tens_q == WRAP_TENS) && (ones_q == WRAP_ONES);

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            carry_q <= 1'b0;
        end else begin
            carry_q <= inc && !clr && at_wrap;
            if (clr) begin
                tens_q <= 4'd0;
                ones_q <= 4'd0;
            end else if (inc) begin
                if (at_wrap) begin
                    tens_q <= 4'd0;
                    ones_q <= 4'd0;
                end else if (ones_q == ONES_MAX) begin
                    tens_q <= tens_q + 4'd1;
                    ones_q <= 4'd0;
                end else begin
                    ones_q <= ones_q + 4'd1;
                end
            end
        end
    end

    assign tens  = tens_q;
    assign ones  = ones_q;
    assign carry = carry_q;

endmodule

// File: rtl/clock_scan_ctrl.sv
// BCD HH:MM:SS clock with set-time FSM, 12/24-hour display and a registered
// multiplexed digit scan feeding an external BCD-to-segment decoder.
module clock_scan_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  RESETn,
    input  logic                  enable,
    input  logic                  tick_sec,
    input  logic                  scan_tick,
    input  logic                  btn_mode,
    input  logic                  btn_inc,
    input  logic                  mode_12h,
    output logic [3:0]            seg_digit,
    output logic                  seg_blank,
    output logic                  seg_dp,
    output logic [NUM_DIGITS-1:0] seg_sel,
    output logic                  pm_led,
    output logic                  sec_led,
    output logic                  day_carry,
    output logic [23:0]           time_bcd
);

    if (!num_digits_ok(NUM_DIGITS)) begin : g_bad_num_digits
        $error("clock_scan_ctrl: NUM_DIGITS must be 4 or 6");
    end

    state_e                state_q;
    logic                  blink_q;
    logic [2:0]            scan_idx_q;
    logic [NUM_DIGITS-1:0] seg_sel_q;
    logic [3:0]            seg_digit_q;
    logic                  seg_blank_q;
    logic                  seg_dp_q;

    logic [3:0] sec_t, sec_o, min_t, min_o, hr_t, hr_o;
    logic       sec_carry, min_carry, hr_carry;

    // Qualified strobes: mode beats inc, and mode in RUN swallows the tick.
    logic mode_p, inc_p, tick_p;
    logic sec_inc, sec_clr, min_inc, hr_inc, sec_max, min_max;

    always_comb begin
        mode_p  = enable && btn_mode;
        inc_p   = enable && btn_inc && !btn_mode;
        tick_p  = enable && tick_sec;
        sec_max = (sec_t == SEC_MIN_TENS_MAX) && (sec_o == ONES_MAX);
        min_max = (min_t == SEC_MIN_TENS_MAX) && (min_o == ONES_MAX);
        sec_clr = mode_p && (state_q == StRun);
        sec_inc = tick_p && !btn_mode && (state_q == StRun);
        min_inc = (sec_inc && sec_max) || (inc_p && (state_q == StSetMin));
        hr_inc  = (sec_inc && sec_max && min_max) || (inc_p && (state_q == StSetHour));
    end

    bcd_pair_counter #(
        .WRAP_TENS (SEC_MIN_TENS_MAX),
        .WRAP_ONES (ONES_MAX)
    ) u_sec (
        .clk    (clk),
        .RESETn (RESETn),
        .inc    (sec_inc),
        .clr    (sec_clr),
        .tens   (sec_t),
        .ones   (sec_o),
        .carry  (sec_carry)
    );

    bcd_pair_counter #(
        .WRAP_TENS (SEC_MIN_TENS_MAX),
        .WRAP_ONES (ONES_MAX)
    ) u_min (
        .clk    (clk),
        .RESETn (RESETn),
        .inc    (min_inc),
        .clr    (1'b0),
        .tens   (min_t),
        .ones   (min_o),
        .carry  (min_carry)
    );

    bcd_pair_counter #(
        .WRAP_TENS (HOUR_WRAP[7:4]),
        .WRAP_ONES (HOUR_WRAP[3:0])
    ) u_hour (
        .clk    (clk),
        .RESETn (RESETn),
        .inc    (hr_inc),
        .clr    (1'b0),
        .tens   (hr_t),
        .ones   (hr_o),
        .carry  (hr_carry)
    );

    // Only the midnight rollover wraps all three counters in the same cycle.
    assign day_carry = sec_carry && min_carry && hr_carry;
    assign time_bcd  = {hr_t, hr_o, min_t, min_o, sec_t, sec_o};
    assign sec_led   = (state_q == StRun) ? sec_o[0] : 1'b1;

    logic       is_pm;
    logic [3:0] disp_t, disp_o;

    always_comb begin
        is_pm  = (hr_t == 4'd2) || ((hr_t == 4'd1) && (hr_o >= 4'd2));
        disp_t = hr_t;
        disp_o = hr_o;
        if (mode_12h) begin
            if (hr_t == 4'd0 && hr_o == 4'd0) begin
                disp_t = 4'd1;
                disp_o = 4'd2;
            end else if (hr_t == 4'd1 && hr_o >= 4'd3) begin
                disp_t = 4'd0;
                disp_o = hr_o - 4'd2;
            end else if (hr_t == 4'd2 && hr_o <= 4'd1) begin
                disp_t = 4'd0;
                disp_o = hr_o + 4'd8;
            end else if (hr_t == 4'd2) begin
                disp_t = 4'd1;
                disp_o = hr_o - 4'd2;
            end
        end
    end

    assign pm_led = mode_12h && is_pm;

    // field numbers digits of HHMMSS from the right; a 4-digit display starts at min_o.
    logic [2:0]            field;
    logic [3:0]            field_val;
    logic                  field_dark;
    logic                  field_dp;
    logic [NUM_DIGITS-1:0] sel_hot;

    always_comb begin
        field = scan_idx_q + ((NUM_DIGITS == 4) ? 3'd2 : 3'd0);
        case (field)
            3'd0:    field_val = sec_o;
            3'd1:    field_val = sec_t;
            3'd2:    field_val = min_o;
            3'd3:    field_val = min_t;
            3'd4:    field_val = disp_o;
            3'd5:    field_val = disp_t;
            default: field_val = 4'd0;
        endcase
        field_dark = ((field == 3'd5) && mode_12h && (disp_t == 4'd0))
                  || (blink_q && (((state_q == StSetHour) && (field >= 3'd4))
                               || ((state_q == StSetMin)
                                   && ((field == 3'd2) || (field == 3'd3)))));
        field_dp = (field == 3'd4) && sec_o[0];
        sel_hot  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_hot[i] = (scan_idx_q == 3'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            state_q     <= StRun;
            blink_q     <= 1'b0;
            scan_idx_q  <= 3'd0;
            seg_sel_q   <= {NUM_DIGITS{SEL_ACTIVE_LOW}};
            seg_digit_q <= 4'd0;
            seg_blank_q <= 1'b1;
            seg_dp_q    <= 1'b0;
        end else begin
            if (mode_p) begin
                unique case (state_q)
                    StRun:     state_q <= StSetHour;
                    StSetHour: state_q <= StSetMin;
                    StSetMin:  state_q <= StRun;
                    default:   state_q <= StRun;
                endcase
            end
            if (tick_p) begin
                blink_q <= !blink_q;
            end
            // Scan runs regardless of enable so the display never freezes on one digit.
            if (scan_tick) begin
                seg_sel_q   <= SEL_ACTIVE_LOW ? ~sel_hot : sel_hot;
                seg_digit_q <= field_val;
                seg_blank_q <= field_dark;
                seg_dp_q    <= field_dp;
                scan_idx_q  <= (scan_idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx_q + 3'd1;
            end
        end
    end

    assign seg_sel   = seg_sel_q;
    assign seg_digit = seg_digit_q;
    assign seg_blank = seg_blank_q;
    assign seg_dp    = seg_dp_q;

endmodule

// File: tb/tb_clock_scan_ctrl.sv
// Directed bench for clock_scan_ctrl (4 digits, active-low select).
module tb_clock_scan_ctrl;

    logic        clk;
    logic        RESETn;
    logic        enable;
    logic        tick_sec;
    logic        scan_tick;
    logic        btn_mode;
    logic        btn_inc;
    logic        mode_12h;
    logic [3:0]  seg_digit;
    logic        seg_blank;
    logic        seg_dp;
    logic [3:0]  seg_sel;
    logic        pm_led;
    logic        sec_led;
    logic        day_carry;
    logic [23:0] time_bcd;

    int checks   = 0;
    int failures = 0;
    int next_idx = 0;

    clock_scan_ctrl #(
        .NUM_DIGITS     (4),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .RESETn    (RESETn),
        .enable    (enable),
        .tick_sec  (tick_sec),
        .scan_tick (scan_tick),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .mode_12h  (mode_12h),
        .seg_digit (seg_digit),
        .seg_blank (seg_blank),
        .seg_dp    (seg_dp),
        .seg_sel   (seg_sel),
        .pm_led    (pm_led),
        .sec_led   (sec_led),
        .day_carry (day_carry),
        .time_bcd  (time_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1;
        cyc();
        btn_mode = 1'b0;
    endtask

    task automatic pulse_inc(input int n);
        repeat (n) begin
            btn_inc = 1'b1;
            cyc();
            btn_inc = 1'b0;
        end
    endtask

    task automatic pulse_tick(input int n);
        repeat (n) begin
            tick_sec = 1'b1;
            cyc();
            tick_sec = 1'b0;
        end
    endtask

    task automatic pulse_scan();
        scan_tick = 1'b1;
        cyc();
        scan_tick = 1'b0;
        next_idx = (next_idx + 1) % 4;
    endtask

    // After this the registered outputs show digit d.
    task automatic show_digit(input int d);
        for (int k = 0; k < 4 && next_idx != d; k++) pulse_scan();
        pulse_scan();
    endtask

    task automatic do_reset();
        RESETn    = 1'b0;
        enable    = 1'b1;
        tick_sec  = 1'b0;
        scan_tick = 1'b0;
        btn_mode  = 1'b0;
        btn_inc   = 1'b0;
        mode_12h  = 1'b0;
        cyc();
        cyc();
        RESETn   = 1'b1;
        next_idx = 0;
    endtask

    task automatic test_reset();
        do_reset();
        pulse_tick(2);
        pulse_scan();
        do_reset();
        checks++;
        if (seg_sel !== 4'b1111) begin
            failures++;
            $display("FAIL reset_sel: got %b want 1111", seg_sel);
        end
        checks++;
        if (seg_digit !== 4'd0) begin
            failures++;
            $display("FAIL reset_digit: got %h want 0", seg_digit);
        end
        checks++;
        if ({seg_blank, seg_dp, pm_led, sec_led, day_carry} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 10000",
                     {seg_blank, seg_dp, pm_led, sec_led, day_carry});
        end
        checks++;
        if (time_bcd !== 24'h000000) begin
            failures++;
            $display("FAIL reset_time: got %h want 000000", time_bcd);
        end
    endtask

    task automatic test_scan();
        logic [3:0] one;
        logic [3:0] exp_sel;
        do_reset();
        one = 4'b0001;
        for (int d = 0; d < 3; d++) begin
            exp_sel = ~(one << d);
            pulse_scan();
            checks++;
            if (seg_sel !== exp_sel) begin
                failures++;
                $display("FAIL scan_sel[%0d]: got %b want %b", d, seg_sel, exp_sel);
            end
            checks++;
            if (seg_digit !== 4'd0 || seg_blank !== 1'b0) begin
                failures++;
                $display("FAIL scan_digit[%0d]: got %h/%b want 0/0", d, seg_digit, seg_blank);
            end
        end
        checks++;
        if (time_bcd !== 24'h000000) begin
            failures++;
            $display("FAIL scan_time: got %h want 000000", time_bcd);
        end
    endtask

    task automatic test_rollover();
        do_reset();
        pulse_mode();
        pulse_inc(23);
        pulse_mode();
        pulse_inc(59);
        pulse_mode();
        pulse_tick(58);
        checks++;
        if (time_bcd !== 24'h235958) begin
            failures++;
            $display("FAIL preload: got %h want 235958", time_bcd);
        end
        pulse_tick(1);
        checks++;
        if (time_bcd !== 24'h235959 || day_carry !== 1'b0) begin
            failures++;
            $display("FAIL pre_wrap: got %h/%b want 235959/0", time_bcd, day_carry);
        end
        pulse_tick(1);
        checks++;
        if (time_bcd !== 24'h000000 || day_carry !== 1'b1) begin
            failures++;
            $display("FAIL day_wrap: got %h/%b want 000000/1", time_bcd, day_carry);
        end
        cyc();
        checks++;
        if (day_carry !== 1'b0) begin
            failures++;
            $display("FAIL day_carry_width: got %b want 0", day_carry);
        end
    endtask

    task automatic test_set();
        do_reset();
        pulse_tick(3);
        pulse_mode();
        checks++;
        if (time_bcd !== 24'h000000 || sec_led !== 1'b1) begin
            failures++;
            $display("FAIL set_entry: got %h/%b want 000000/1", time_bcd, sec_led);
        end
        pulse_inc(13);
        checks++;
        if (time_bcd !== 24'h130000) begin
            failures++;
            $display("FAIL set_hour13: got %h want 130000", time_bcd);
        end
        pulse_inc(11);
        checks++;
        if (time_bcd !== 24'h000000) begin
            failures++;
            $display("FAIL set_hour_wrap: got %h want 000000", time_bcd);
        end
        pulse_mode();
        pulse_inc(61);
        checks++;
        if (time_bcd !== 24'h000100) begin
            failures++;
            $display("FAIL set_min_wrap: got %h want 000100", time_bcd);
        end
        pulse_mode();
        checks++;
        if (sec_led !== 1'b0) begin
            failures++;
            $display("FAIL set_exit_led: got %b want 0", sec_led);
        end
        pulse_tick(1);
        checks++;
        if (time_bcd !== 24'h000101) begin
            failures++;
            $display("FAIL set_exit_run: got %h want 000101", time_bcd);
        end
    endtask

    task automatic test_12h();
        do_reset();
        mode_12h = 1'b1;
        show_digit(3);
        checks++;
        if (seg_digit !== 4'd1 || seg_blank !== 1'b0) begin
            failures++;
            $display("FAIL h12_00_tens: got %h/%b want 1/0", seg_digit, seg_blank);
        end
        show_digit(2);
        checks++;
        if (seg_digit !== 4'd2 || pm_led !== 1'b0) begin
            failures++;
            $display("FAIL h12_00_ones: got %h/pm%b want 2/pm0", seg_digit, pm_led);
        end
        pulse_mode();
        pulse_inc(12);
        show_digit(3);
        checks++;
        if (seg_digit !== 4'd1 || seg_blank !== 1'b0 || pm_led !== 1'b1) begin
            failures++;
            $display("FAIL h12_12_tens: got %h/%b/pm%b want 1/0/pm1", seg_digit, seg_blank, pm_led);
        end
        show_digit(2);
        checks++;
        if (seg_digit !== 4'd2) begin
            failures++;
            $display("FAIL h12_12_ones: got %h want 2", seg_digit);
        end
        pulse_inc(1);
        show_digit(3);
        checks++;
        if (seg_blank !== 1'b1 || pm_led !== 1'b1) begin
            failures++;
            $display("FAIL h12_13_tens: got blank%b/pm%b want blank1/pm1", seg_blank, pm_led);
        end
        show_digit(2);
        checks++;
        if (seg_digit !== 4'd1 || seg_blank !== 1'b0) begin
            failures++;
            $display("FAIL h12_13_ones: got %h/%b want 1/0", seg_digit, seg_blank);
        end
        // A tick in SET_HOUR flips the blink phase but must not move seconds.
        pulse_tick(1);
        show_digit(2);
        checks++;
        if (seg_blank !== 1'b1 || time_bcd !== 24'h130000) begin
            failures++;
            $display("FAIL blink_hour: got %b/%h want 1/130000", seg_blank, time_bcd);
        end
        show_digit(1);
        checks++;
        if (seg_blank !== 1'b0) begin
            failures++;
            $display("FAIL blink_min_lit: got %b want 0", seg_blank);
        end
        mode_12h = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        pulse_mode();
        pulse_inc(5);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        cyc();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        checks++;
        if (time_bcd !== 24'h050000) begin
            failures++;
            $display("FAIL mode_beats_inc: got %h want 050000", time_bcd);
        end
        pulse_inc(1);
        checks++;
        if (time_bcd !== 24'h050100) begin
            failures++;
            $display("FAIL now_set_min: got %h want 050100", time_bcd);
        end
        pulse_mode();
        pulse_tick(2);
        checks++;
        if (time_bcd !== 24'h050102) begin
            failures++;
            $display("FAIL run_again: got %h want 050102", time_bcd);
        end
        btn_mode = 1'b1;
        tick_sec = 1'b1;
        cyc();
        btn_mode = 1'b0;
        tick_sec = 1'b0;
        checks++;
        if (time_bcd !== 24'h050100 || sec_led !== 1'b1) begin
            failures++;
            $display("FAIL mode_beats_tick: got %h/%b want 050100/1", time_bcd, sec_led);
        end
        pulse_inc(1);
        checks++;
        if (time_bcd !== 24'h060100) begin
            failures++;
            $display("FAIL now_set_hour: got %h want 060100", time_bcd);
        end
    endtask

    task automatic test_enable();
        do_reset();
        pulse_tick(3);
        enable = 1'b0;
        pulse_tick(5);
        pulse_inc(2);
        pulse_mode();
        checks++;
        if (time_bcd !== 24'h000003 || sec_led !== 1'b1) begin
            failures++;
            $display("FAIL hold_time: got %h/%b want 000003/1", time_bcd, sec_led);
        end
        show_digit(2);
        checks++;
        if (seg_sel !== 4'b1011 || seg_dp !== 1'b1) begin
            failures++;
            $display("FAIL hold_scan2: got %b/dp%b want 1011/dp1", seg_sel, seg_dp);
        end
        show_digit(3);
        checks++;
        if (seg_sel !== 4'b0111 || seg_dp !== 1'b0) begin
            failures++;
            $display("FAIL hold_scan3: got %b/dp%b want 0111/dp0", seg_sel, seg_dp);
        end
        enable = 1'b1;
        pulse_tick(1);
        checks++;
        if (time_bcd !== 24'h000004) begin
            failures++;
            $display("FAIL hold_still_run: got %h want 000004", time_bcd);
        end
    endtask

    task automatic test_reset_mid_set();
        pulse_mode();
        pulse_inc(3);
        pulse_mode();
        pulse_inc(2);
        checks++;
        if (time_bcd !== 24'h030200) begin
            failures++;
            $display("FAIL partial_set: got %h want 030200", time_bcd);
        end
        do_reset();
        checks++;
        if (time_bcd !== 24'h000000 || sec_led !== 1'b0 || seg_sel !== 4'b1111) begin
            failures++;
            $display("FAIL reset_mid_set: got %h/%b/%b want 000000/0/1111",
                     time_bcd, sec_led, seg_sel);
        end
        pulse_tick(1);
        checks++;
        if (time_bcd !== 24'h000001) begin
            failures++;
            $display("FAIL reset_to_run: got %h want 000001", time_bcd);
        end
    endtask

    initial begin
        RESETn    = 1'b0;
        enable    = 1'b1;
        tick_sec  = 1'b0;
        scan_tick = 1'b0;
        btn_mode  = 1'b0;
        btn_inc   = 1'b0;
        mode_12h  = 1'b0;
        test_reset();
        test_scan();
        test_rollover();
        test_set();
        test_12h();
        test_priority();
        test_enable();
        test_reset_mid_set();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
